register_bank: RTL and testbench



---
 rtl/rb_pkg.sv | 15 +
 rtl/register_bank_rdport.sv | 81 ++++++++
 rtl/register_bank.sv | 115 +++++++++++
 tb/tb_register_bank.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared constants and helpers for the register bank and its read ports.
// Address validity lives here so storage and read ports apply the same rule.
package rb_pkg;

   localparam int unsigned RB_DATA_WIDTH = 32;
   localparam int unsigned RB_NUM_REGS   = 16;

   // Invalid addresses are out of range, or R0 when it is hardwired to zero.
   function automatic logic addr_valid(input int unsigned addr,
                                       input int unsigned num_regs,
                                       input logic        zero_reg);
      return (addr < num_regs) && !(zero_reg && (addr == 0));
   endfunction

endpackage

// File: rtl/register_bank_rdport.sv
// One read port of the register bank: write bypass, invalid-address masking
// and an optional output register.
module register_bank_rdport
   import rb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RB_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = RB_NUM_REGS,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1,
   parameter int unsigned READ_REG   = 0
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] stored_data,
   input  logic                  stored_pend,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  lock_en,
   input  logic [ADDR_WIDTH-1:0] lock_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_pend
);

   logic                  addr_ok;
   logic                  wr_hit;
   logic                  lock_hit;
   logic [DATA_WIDTH-1:0] val_data;
   logic                  val_pend;

   always_comb begin
      addr_ok  = addr_valid(32'(rd_addr), NUM_REGS, ZERO_REG != 0);
      wr_hit   = (BYPASS != 0) && !flush && wr_en && (wr_addr == rd_addr);
      lock_hit = lock_en && (lock_addr == rd_addr);
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      val_data = '0;
      val_pend = 1'b0;
      // Gating on clear_n keeps a bypassed write from showing while reset is held.
      if (clear_n && addr_ok) begin
         if (wr_hit) begin
            val_data = wr_data;
            val_pend = lock_hit;
         end else begin
            val_data = stored_data;
            val_pend = stored_pend;
         end
      end
   end

   if (READ_REG != 0) begin : g_registered
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  pend_q, pend_d;

      always_comb begin
         data_d = flush ? '0   : val_data;
         pend_d = flush ? 1'b0 : val_pend;
      end

      always_ff @(posedge clock or negedge clear_n) begin
         if (!clear_n) begin
            data_q <= '0;
            pend_q <= 1'b0;
         end else begin
            data_q <= data_d;
            pend_q <= pend_d;
         end
      end

      assign rd_data = data_q;
      assign rd_pend = pend_q;
   end else begin : g_combinational
      logic unused_clock;
      assign unused_clock = clock;
      assign rd_data      = val_data;
      assign rd_pend      = val_pend;
   end

endmodule

// File: rtl/register_bank.sv
// Multi-register file with two read ports, one write port and a per-register
// pending bit that tracks outstanding results between decode and writeback.
module register_bank
   import rb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RB_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = RB_NUM_REGS,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1,
   parameter int unsigned READ_REG   = 0
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  lock_en,
   input  logic [ADDR_WIDTH-1:0] lock_addr,
   input  logic [ADDR_WIDTH-1:0] rd_a_addr,
   output logic [DATA_WIDTH-1:0] rd_a_data,
   output logic                  rd_a_pend,
   input  logic [ADDR_WIDTH-1:0] rd_b_addr,
   output logic [DATA_WIDTH-1:0] rd_b_data,
   output logic                  rd_b_pend,
   output logic                  any_pend
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   pend_q, pend_d;
   logic                  wr_ok;
   logic                  lock_ok;

   always_comb begin
      regs_d  = regs_q;
      pend_d  = pend_q;
      wr_ok   = wr_en   && addr_valid(32'(wr_addr),   NUM_REGS, ZERO_REG != 0);
      lock_ok = lock_en && addr_valid(32'(lock_addr), NUM_REGS, ZERO_REG != 0);
      if (flush) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_d[i] = '0;
         pend_d = '0;
      end else begin
         if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
         end
         // Applied after the write so a same-cycle producer re-arms the pending bit.
         if (lock_ok) pend_d[lock_addr] = 1'b1;
      end
   end

   // NOTE: the storage is a flop array cleared by reset, because every register must read 0
   // immediately after clear_n; a RAM macro could not provide that.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
         pend_q <= '0;
      end else begin
         // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   assign any_pend = |pend_q;

   register_bank_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS),
      .READ_REG   (READ_REG)
   ) u_rd_a (
      .clock       (clock),
      .clear_n     (clear_n),
      .flush       (flush),
      .rd_addr     (rd_a_addr),
      .stored_data (regs_q[rd_a_addr]),
      .stored_pend (pend_q[rd_a_addr]),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .lock_en     (lock_en),
      .lock_addr   (lock_addr),
      .rd_data     (rd_a_data),
      .rd_pend     (rd_a_pend)
   );

   register_bank_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS),
      .READ_REG   (READ_REG)
   ) u_rd_b (
      .clock       (clock),
      .clear_n     (clear_n),
      .flush       (flush),
      .rd_addr     (rd_b_addr),
      .stored_data (regs_q[rd_b_addr]),
      .stored_pend (pend_q[rd_b_addr]),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .lock_en     (lock_en),
      .lock_addr   (lock_addr),
      .rd_data     (rd_b_data),
      .rd_pend     (rd_b_pend)
   );

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: three configurations share one stimulus stream and
// are checked every cycle against an array-based model plus literal expectations.
module tb_register_bank;

   logic        clock;
   logic        clear_n;
   logic        flush;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        lock_en;
   logic [3:0]  lock_addr;
   logic [3:0]  rd_a_addr;
   logic [3:0]  rd_b_addr;

   logic [31:0] a_data [3];
   logic [31:0] b_data [3];
   logic        a_pend [3];
   logic        b_pend [3];
   logic        any_p  [3];

   int n_checks = 0;
   int n_errors = 0;

   // Config 0: defaults. Config 1: no bypass, R0 writable. Config 2: registered reads, 12 regs.
   function automatic int cfg_nregs(input int c);
      return (c == 2) ? 12 : 16;
   endfunction
   function automatic bit cfg_zero(input int c);
      return c != 1;
   endfunction
   function automatic bit cfg_bypass(input int c);
      return c != 1;
   endfunction
   function automatic bit cfg_rr(input int c);
      return c == 2;
   endfunction

   register_bank #(.DATA_WIDTH(32), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) dut0 (
      .clock(clock), .clear_n(clear_n), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr),
      .rd_a_addr(rd_a_addr), .rd_a_data(a_data[0]), .rd_a_pend(a_pend[0]),
      .rd_b_addr(rd_b_addr), .rd_b_data(b_data[0]), .rd_b_pend(b_pend[0]), .any_pend(any_p[0]));

   register_bank #(.DATA_WIDTH(32), .NUM_REGS(16), .ZERO_REG(0), .BYPASS(0), .READ_REG(0)) dut1 (
      .clock(clock), .clear_n(clear_n), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr),
      .rd_a_addr(rd_a_addr), .rd_a_data(a_data[1]), .rd_a_pend(a_pend[1]),
      .rd_b_addr(rd_b_addr), .rd_b_data(b_data[1]), .rd_b_pend(b_pend[1]), .any_pend(any_p[1]));

   register_bank #(.DATA_WIDTH(32), .NUM_REGS(12), .ZERO_REG(1), .BYPASS(1), .READ_REG(1)) dut2 (
      .clock(clock), .clear_n(clear_n), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr),
      .rd_a_addr(rd_a_addr), .rd_a_data(a_data[2]), .rd_a_pend(a_pend[2]),
      .rd_b_addr(rd_b_addr), .rd_b_data(b_data[2]), .rd_b_pend(b_pend[2]), .any_pend(any_p[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem   [3][16];
   logic        m_pend  [3][16];
   logic [31:0] m_cap_d [2];
   logic        m_cap_p [2];

   function automatic bit m_valid(input int c, input logic [3:0] a);
      return (int'(a) < cfg_nregs(c)) && !(cfg_zero(c) && (a == 4'd0));
   endfunction

   // Value a port would present this cycle for address a, before any output register.
   function automatic void m_read(input int c, input logic [3:0] a,
                                  output logic [31:0] d, output logic p);
      d = 32'd0;
      p = 1'b0;
      if (!m_valid(c, a)) return;
      if (cfg_bypass(c) && !flush && wr_en && (wr_addr == a)) begin
         d = wr_data;
         p = lock_en && (lock_addr == a);
      end else begin
         d = m_mem[c][a];
         p = m_pend[c][a];
      end
   endfunction

   function automatic void m_out(input int c, input bit port_b,
                                 output logic [31:0] d, output logic p);
      if (!clear_n) begin
         d = 32'd0;
         p = 1'b0;
      end else if (cfg_rr(c)) begin
         d = m_cap_d[port_b];
         p = m_cap_p[port_b];
      end else begin
         m_read(c, port_b ? rd_b_addr : rd_a_addr, d, p);
      end
   endfunction

   function automatic logic m_any(input int c);
      logic r = 1'b0;
      for (int i = 0; i < cfg_nregs(c); i++) r = r | m_pend[c][i];
      return r;
   endfunction

   always @(posedge clock or negedge clear_n) begin : model_update
      logic [31:0] d;
      logic        p;
      if (!clear_n) begin
         for (int c = 0; c < 3; c++)
            for (int i = 0; i < 16; i++) begin
               m_mem[c][i]  <= 32'd0;
               m_pend[c][i] <= 1'b0;
            end
         for (int k = 0; k < 2; k++) begin
            m_cap_d[k] <= 32'd0;
            m_cap_p[k] <= 1'b0;
         end
      end else begin
         m_read(2, rd_a_addr, d, p);
         m_cap_d[0] <= flush ? 32'd0 : d;
         m_cap_p[0] <= flush ? 1'b0  : p;
         m_read(2, rd_b_addr, d, p);
         m_cap_d[1] <= flush ? 32'd0 : d;
         m_cap_p[1] <= flush ? 1'b0  : p;
         for (int c = 0; c < 3; c++) begin
            if (flush) begin
               for (int i = 0; i < 16; i++) begin
                  m_mem[c][i]  <= 32'd0;
                  m_pend[c][i] <= 1'b0;
               end
            end else begin
               if (wr_en && m_valid(c, wr_addr)) begin
                  m_mem[c][wr_addr]  <= wr_data;
                  m_pend[c][wr_addr] <= 1'b0;
               end
               if (lock_en && m_valid(c, lock_addr)) m_pend[c][lock_addr] <= 1'b1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin : compare
      logic [31:0] d;
      logic        p;
      for (int c = 0; c < 3; c++) begin
         m_out(c, 1'b0, d, p);
         check($sformatf("cmp dut%0d rd_a_data", c), a_data[c], d);
         check($sformatf("cmp dut%0d rd_a_pend", c), 32'(a_pend[c]), 32'(p));
         m_out(c, 1'b1, d, p);
         check($sformatf("cmp dut%0d rd_b_data", c), b_data[c], d);
         check($sformatf("cmp dut%0d rd_b_pend", c), 32'(b_pend[c]), 32'(p));
         check($sformatf("cmp dut%0d any_pend", c), 32'(any_p[c]), 32'(m_any(c)));
      end
   end

   task automatic check_all_zero(input string tag);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("%s dut%0d rd_a_data", tag, c), a_data[c], 32'd0);
         check($sformatf("%s dut%0d rd_a_pend", tag, c), 32'(a_pend[c]), 32'd0);
         check($sformatf("%s dut%0d rd_b_data", tag, c), b_data[c], 32'd0);
         check($sformatf("%s dut%0d rd_b_pend", tag, c), 32'(b_pend[c]), 32'd0);
         check($sformatf("%s dut%0d any_pend", tag, c), 32'(any_p[c]), 32'd0);
      end
   endtask

   // Drive one cycle of inputs just after posedge, return just after the following negedge.
   task automatic step(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                       input bit le, input logic [3:0] la, input bit fl,
                       input logic [3:0] ra, input logic [3:0] rb);
      @(posedge clock);
      #1;
      wr_en     = we;
      wr_addr   = wa;
      wr_data   = wd;
      lock_en   = le;
      lock_addr = la;
      flush     = fl;
      rd_a_addr = ra;
      rd_b_addr = rb;
      @(negedge clock);
      #1;
   endtask

   task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, ra, rb);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      clear_n   = 1'b0;
      flush     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = 4'd0;
      wr_data   = 32'd0;
      lock_en   = 1'b0;
      lock_addr = 4'd0;
      rd_a_addr = 4'd0;
      rd_b_addr = 4'd0;

      @(negedge clock);
      #1;
      check_all_zero("reset");
      @(posedge clock);
      #1;
      clear_n = 1'b1;

      // Write R5, forwarded in the write cycle only with bypass.
      step(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd5, 4'd5);
      check("bypass r5 dut0", a_data[0], 32'hDEADBEEF);
      check("old r5 dut1", a_data[1], 32'd0);
      idle(4'd5, 4'd5);
      check("read r5 a dut0", a_data[0], 32'hDEADBEEF);
      check("read r5 b dut0", b_data[0], 32'hDEADBEEF);
      check("read r5 dut1", a_data[1], 32'hDEADBEEF);
      check("rr r5 dut2", a_data[2], 32'hDEADBEEF);

      // R0 write: dropped when hardwired, kept otherwise.
      step(1'b1, 4'd0, 32'h1234, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      idle(4'd0, 4'd0);
      check("zero r0 dut0", a_data[0], 32'd0);
      check("r0 writable dut1", a_data[1], 32'h1234);

      // Bypass versus next-cycle visibility.
      step(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 4'd0, 1'b0, 4'd7, 4'd7);
      check("bypass r7 dut0", a_data[0], 32'hA5A5A5A5);
      check("nobypass r7 old dut1", a_data[1], 32'd0);
      idle(4'd7, 4'd7);
      check("nobypass r7 new dut1", a_data[1], 32'hA5A5A5A5);

      // Scoreboard: lock, then write clears, then lock+write keeps pending.
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd3, 4'd3);
      check("lock not bypassed", 32'(a_pend[0]), 32'd0);
      check("lock any not yet", 32'(any_p[0]), 32'd0);
      idle(4'd3, 4'd3);
      check("lock r3 pend", 32'(a_pend[0]), 32'd1);
      check("lock r3 any", 32'(any_p[0]), 32'd1);
      step(1'b1, 4'd3, 32'h42, 1'b0, 4'd0, 1'b0, 4'd3, 4'd3);
      check("wr r3 bypass data", a_data[0], 32'h42);
      check("wr r3 bypass pend", 32'(a_pend[0]), 32'd0);
      check("wr r3 any stored", 32'(any_p[0]), 32'd1);
      check("wr r3 nobypass pend", 32'(a_pend[1]), 32'd1);
      idle(4'd3, 4'd3);
      check("r3 any cleared", 32'(any_p[0]), 32'd0);
      check("r3 pend cleared dut1", 32'(a_pend[1]), 32'd0);
      step(1'b1, 4'd3, 32'h77, 1'b1, 4'd3, 1'b0, 4'd3, 4'd3);
      check("lockwr bypass data", a_data[0], 32'h77);
      check("lockwr bypass pend", 32'(a_pend[0]), 32'd1);
      idle(4'd3, 4'd3);
      check("lockwr data", a_data[0], 32'h77);
      check("lockwr pend", 32'(a_pend[0]), 32'd1);
      check("lockwr data dut1", a_data[1], 32'h77);

      // Flush with a competing write.
      for (int i = 1; i <= 4; i++)
         step(1'b1, 4'(i), 32'(i * 17), 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd1, 4'd2);
      step(1'b1, 4'd1, 32'hFFFF, 1'b0, 4'd0, 1'b1, 4'd1, 4'd2);
      check("flush no bypass", a_data[0], 32'd17);
      check("flush pend r2 stored", 32'(b_pend[0]), 32'd1);
      check("flush any stored", 32'(any_p[0]), 32'd1);
      idle(4'd1, 4'd2);
      check("post flush r1", a_data[0], 32'd0);
      check("post flush r2", b_data[0], 32'd0);
      check("post flush any", 32'(any_p[0]), 32'd0);
      check("post flush rr r1", a_data[2], 32'd0);
      check("post flush rr any", 32'(any_p[2]), 32'd0);

      // Registered-read latency on R9.
      step(1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      idle(4'd9, 4'd9);
      check("rr r9 not yet", a_data[2], 32'd0);
      check("comb r9", a_data[0], 32'h99);
      idle(4'd0, 4'd0);
      check("rr r9 one later", a_data[2], 32'h99);

      // Address 13: invalid for 12 registers, valid for 16.
      step(1'b1, 4'd13, 32'hBAD, 1'b0, 4'd0, 1'b0, 4'd13, 4'd13);
      check("addr13 bypass dut0", a_data[0], 32'hBAD);
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd13, 4'd13);
      check("addr13 rr data", a_data[2], 32'd0);
      check("addr13 rr pend", 32'(a_pend[2]), 32'd0);
      check("addr13 stored dut0", a_data[0], 32'hBAD);
      idle(4'd13, 4'd13);
      check("addr13 lock dropped", 32'(any_p[2]), 32'd0);
      check("addr13 lock dut0", 32'(a_pend[0]), 32'd1);
      for (int i = 0; i < 12; i++) idle(4'(i), 4'(11 - i));
      idle(4'd0, 4'd0);

      // Reset mid-operation with data and pending bits held.
      step(1'b1, 4'd6, 32'h6666, 1'b1, 4'd5, 1'b0, 4'd5, 4'd6);
      idle(4'd5, 4'd6);
      check("pre reset r6", b_data[0], 32'h6666);
      check("pre reset r5 pend", 32'(a_pend[0]), 32'd1);
      wr_en     = 1'b1;
      wr_addr   = 4'd7;
      wr_data   = 32'hCAFE;
      rd_a_addr = 4'd7;
      #1;
      check("pre reset bypass", a_data[0], 32'hCAFE);
      clear_n = 1'b0;
      #1;
      check_all_zero("async reset");
      @(posedge clock);
      #1;
      wr_en     = 1'b0;
      rd_a_addr = 4'd5;
      @(posedge clock);
      #1;
      clear_n = 1'b1;
      idle(4'd5, 4'd6);
      check("after reset r5 pend", 32'(a_pend[0]), 32'd0);
      check("after reset r6", b_data[0], 32'd0);
      idle(4'd0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
